// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key-schedule blocks: the S-box, the Rcon table,
// the key-generator FSM states and the size constants.
package aes_pkg;

    localparam int KEY_W      = 128;
    localparam int NUM_ROUNDS = 10;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Forward S-box. Entry 0x00 is the top byte of the vector.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // ~b equals 255-b, which turns the byte value into an offset from the LSB end.
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Rounds outside 1..10 return 0. This keeps the lookup total.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backward step of the AES-128 key schedule. It recovers round key r-1 from
// round key r, using the Rcon value of round r.
module aes_inv_key_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [3:0]       round_i,
    output logic [KEY_W-1:0] prev_key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;

    assign w0 = key_i[127:96];
    assign w1 = key_i[95:64];
    assign w2 = key_i[63:32];
    assign w3 = key_i[31:0];

    // Undo the chained XORs from the last word back to the first. p3 is the
    // recovered previous w3, and it feeds the SubWord/RotWord term for p0.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon(round_i), 24'h0};

    assign prev_key_o = {p0, p1, p2, p3};

endmodule

// File: rtl/aes_inv_key_gen.sv
// Inverse AES-128 key schedule. Starting from the round-10 key, it emits round keys
// 10 down to 0, one key per accepted beat.
module aes_inv_key_gen
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_last_key,
    input  logic             i_key_ready,
    output logic [KEY_W-1:0] o_rnd_key,
    output logic [3:0]       o_round_num,
    output logic             o_key_valid,
    output logic             o_busy,
    output logic             o_done
);

    aes_state_e       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       round_q, round_d;
    logic [KEY_W-1:0] prev_key;
    logic             accept;

    aes_inv_key_step u_step (
        .key_i      (key_q),
        .round_i    (round_q),
        .prev_key_o (prev_key)
    );

    // Handshake: o_key_valid stays high in EMIT until the consumer accepts with
    // i_key_ready. While it waits, o_rnd_key and o_round_num do not change. A
    // transfer happens on every clock where both signals are high.
    assign accept = (state_q == EMIT) && i_key_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    key_d   = i_last_key;
                    round_d = LAST_ROUND;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (accept) begin
                    if (round_q != 4'd0) begin
                        key_d   = prev_key;
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    // All outputs decode directly from registers, so an async reset clears them at once.
    assign o_rnd_key   = key_q;
    assign o_round_num = round_q;
    assign o_key_valid = (state_q == EMIT);
    assign o_busy      = (state_q == EMIT);
    assign o_done      = (state_q == DONE);

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Self-checking bench for aes_inv_key_gen. It compares against a forward key-expansion
// model with its own derived S-box, plus constant FIPS-197 vectors.
module tb_aes_inv_key_gen;

  localparam logic [127:0] A1_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_K0  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [127:0] i_last_key = '0;
  logic         i_key_ready = 1'b0;
  logic [127:0] o_rnd_key;
  logic [3:0]   o_round_num;
  logic         o_key_valid;
  logic         o_busy;
  logic         o_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];
  logic [127:0] exp_q [$];

  typedef struct {
    logic [127:0] last_key;
    int           round;
    logic [127:0] exp_key;
  } vec_t;
  vec_t vecs [6];

  aes_inv_key_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_last_key  (i_last_key),
    .i_key_ready (i_key_ready),
    .o_rnd_key   (o_rnd_key),
    .o_round_num (o_round_num),
    .o_key_valid (o_key_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // model: GF(2^8) arithmetic, S-box from inverse + affine map, forward expansion
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] bx  = 8'(x);
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, bx);
      end
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    w[0] = key0[127:96]; w[1] = key0[95:64]; w[2] = key0[63:32]; w[3] = key0[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // driver tasks
  // mode 0: ready always 1, mode 1: ready 1,0,0 repeating, mode 2: random ready.
  // Returns at the negedge where DONE is visible.
  task automatic run_seq(input logic [127:0] key0, input int mode, input bit inject);
    int   acc = 0;
    int   cyc = 0;
    bit   held = 0;
    bit   injected = 0;
    logic rdy;
    logic [127:0] hk;
    logic [3:0]   hr;
    expand(key0);
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back(exp_rk[r]);
    i_last_key  = exp_rk[10];
    i_start     = 1'b1;
    i_key_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    chk("first_valid_latency", o_key_valid, 1);
    chk("first_busy", o_busy, 1);
    while (acc < 11 && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      i_key_ready = rdy;
      i_start = 1'b0;
      if (inject && !injected && o_round_num == 4'd5) begin
        i_start    = 1'b1;
        i_last_key = ~exp_rk[10];
        injected   = 1;
      end
      chk("valid_held", o_key_valid, 1);
      if (held) begin
        chk("stall_key_stable", o_rnd_key, hk);
        chk("stall_round_stable", o_round_num, hr);
      end
      chk("round_idx", o_round_num, 10 - acc);
      chk("round_key", o_rnd_key, exp_q[0]);
      if (rdy) begin
        void'(exp_q.pop_front());
        acc++;
        held = 0;
      end else begin
        held = 1;
        hk = o_rnd_key;
        hr = o_round_num;
      end
      @(negedge clk);
      cyc++;
    end
    i_key_ready = 1'b0;
    i_start = 1'b0;
    chk("accept_count", acc, 11);
    if (mode == 0) chk("stream_cycles", cyc, 11);
    chk("done_pulse", o_done, 1);
    chk("done_valid_low", o_key_valid, 0);
    chk("done_busy_low", o_busy, 0);
  endtask

  task automatic finish_idle();
    @(negedge clk);
    chk("idle_done_low", o_done, 0);
    chk("idle_valid_low", o_key_valid, 0);
    chk("idle_busy_low", o_busy, 0);
  endtask

  task automatic get_key(input logic [127:0] k10, input int rnd, output logic [127:0] got);
    got = 'x;
    i_last_key  = k10;
    i_start     = 1'b1;
    i_key_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int j = 0; j < 11; j++) begin
      if (o_key_valid && int'(o_round_num) == rnd) got = o_rnd_key;
      @(negedge clk);
    end
    i_key_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] got;
    vecs[0] = '{A1_K10, 10, A1_K10};
    vecs[1] = '{A1_K10, 9, 128'hac7766f319fadc2128d12941575c006e};
    vecs[2] = '{A1_K10, 1, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3] = '{A1_K10, 0, A1_K0};
    vecs[4] = '{C1_K10, 10, C1_K10};
    vecs[5] = '{C1_K10, 0, C1_K0};

    build_sbox();
    repeat (2) @(negedge clk);
    chk("reset_key", o_rnd_key, 0);
    chk("reset_round", o_round_num, 0);
    chk("reset_valid", o_key_valid, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven fixed vectors.
    for (int v = 0; v < 6; v++) begin
      get_key(vecs[v].last_key, vecs[v].round, got);
      chk($sformatf("vec%0d_round%0d", v, vecs[v].round), got, vecs[v].exp_key);
    end

    // 1: streaming order, A.1
    run_seq(A1_K0, 0, 0);
    chk("a1_final_key", o_rnd_key, A1_K0);
    finish_idle();

    // 2: backpressure 1,0,0,...
    run_seq(A1_K0, 1, 0);
    finish_idle();

    // 3: start while busy at round 5
    run_seq(A1_K0, 0, 1);
    chk("busy_start_final_key", o_rnd_key, A1_K0);
    finish_idle();

    // 4: async reset mid-sequence at round 6
    i_last_key  = A1_K10;
    i_start     = 1'b1;
    i_key_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int j = 0; j < 20 && o_round_num != 4'd6; j++) @(negedge clk);
    chk("reach_round6", o_round_num, 6);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_key", o_rnd_key, 0);
    chk("async_rst_round", o_round_num, 0);
    chk("async_rst_valid", o_key_valid, 0);
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_done", o_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    i_key_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_valid", o_key_valid, 0);
    chk("post_rst_idle_busy", o_busy, 0);
    run_seq(A1_K0, 0, 0);
    chk("post_rst_final_key", o_rnd_key, A1_K0);
    finish_idle();

    // 5: back-to-back, start in DONE ignored, start one cycle later accepted
    run_seq(A1_K0, 0, 0);
    i_last_key = C1_K10;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("done_start_ignored_valid", o_key_valid, 0);
    chk("done_start_ignored_done", o_done, 0);
    chk("idle_key_holds", o_rnd_key, A1_K0);
    run_seq(C1_K0, 0, 0);
    chk("c1_final_key", o_rnd_key, C1_K0);
    finish_idle();

    // 6: random keys against forward expansion, random ready
    for (int n = 0; n < 100; n++) begin
      run_seq({$urandom, $urandom, $urandom, $urandom}, 2, 0);
      finish_idle();
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
